// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame buffer slice.
// Holds the default data widths and the sequencer state encoding.
package fft_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cplx_ram.sv
// Complex frame memory: 2**ADDR_W words of {Re, Im}.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset (host read register only)
//   ra_*/rb_*                 two combinational read ports (engine top/bottom)
//   hr_addr_i, hr_re_o/im_o   registered host read port, 1 cycle latency
//   wa_*                      top write port, wins on an address clash
//   wb_*                      bottom write port
// Memory contents are never reset.
module cplx_ram
    import fft_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] ra_addr_i,
    output logic [WORD_W-1:0] ra_re_o,
    output logic [WORD_W-1:0] ra_im_o,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [WORD_W-1:0] rb_re_o,
    output logic [WORD_W-1:0] rb_im_o,
    input  logic [ADDR_W-1:0] hr_addr_i,
    output logic [WORD_W-1:0] hr_re_o,
    output logic [WORD_W-1:0] hr_im_o,
    input  logic              wa_en_i,
    input  logic [ADDR_W-1:0] wa_addr_i,
    input  logic [WORD_W-1:0] wa_re_i,
    input  logic [WORD_W-1:0] wa_im_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [WORD_W-1:0] wb_re_i,
    input  logic [WORD_W-1:0] wb_im_i
);

    localparam int N = 1 << ADDR_W;

    logic [2*WORD_W-1:0] mem_q [N];
    logic                wb_keep;

    // Bottom write is dropped when the top port targets the same word.
    assign wb_keep = wb_en_i && !(wa_en_i && (wa_addr_i == wb_addr_i));

    always_ff @(posedge clk_i) begin
        if (wb_keep) begin
            mem_q[wb_addr_i] <= {wb_re_i, wb_im_i};
        end
        if (wa_en_i) begin
            mem_q[wa_addr_i] <= {wa_re_i, wa_im_i};
        end
    end

    assign {ra_re_o, ra_im_o} = mem_q[ra_addr_i];
    assign {rb_re_o, rb_im_o} = mem_q[rb_addr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hr_re_o <= '0;
            hr_im_o <= '0;
        end else begin
            {hr_re_o, hr_im_o} <= mem_q[hr_addr_i];
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Frame buffer and sequencer around a butterfly FFT engine.
// Loads N real samples (stored as Re = sign-extended sample, Im = 0), starts the
// engine, services its in-place butterfly writes and holds the spectrum for readout.
// Ports:
//   Clk, Reset_n                  clock, async active-low reset
//   Wr_en, Data_in                sample load strobe and data
//   Start, Ack                    host run request / release of DONE
//   Rd_addr -> Rd_re/Rd_im/Rd_mag registered host readout (1 cycle)
//   Full, Busy, Done, Err         status flags
//   fft_start/fft_done            engine launch pulse / completion
//   i_top/i_bot, x_*, fft_wr_en, y_*  engine butterfly memory interface
//   dbg_state                     current sequencer state
// Host handshake: Start is a level sampled only in LOAD with Full=1; it launches a
// run with a single-cycle fft_start. Done stays high until Ack is sampled in DONE.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int AUTO_START = 0,
    parameter int TIMEOUT    = 65535
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Wr_en,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              Start,
    input  logic              Ack,
    input  logic [ADDR_W-1:0] Rd_addr,
    output logic [WORD_W-1:0] Rd_re,
    output logic [WORD_W-1:0] Rd_im,
    output logic [WORD_W:0]   Rd_mag,
    output logic              Full,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              fft_start,
    input  logic              fft_done,
    input  logic [ADDR_W-1:0] i_top,
    input  logic [ADDR_W-1:0] i_bot,
    output logic [WORD_W-1:0] x_top_re,
    output logic [WORD_W-1:0] x_top_im,
    output logic [WORD_W-1:0] x_bot_re,
    output logic [WORD_W-1:0] x_bot_im,
    input  logic              fft_wr_en,
    input  logic [WORD_W-1:0] y_top_re,
    input  logic [WORD_W-1:0] y_top_im,
    input  logic [WORD_W-1:0] y_bot_re,
    input  logic [WORD_W-1:0] y_bot_im,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W:0] N_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e          state_q;
    logic [ADDR_W:0] count_q, count_d;
    logic [31:0]     wdog_q;
    logic            full_q, busy_q, done_q, err_q, start_q;

    logic              load_we, run_we, top_we;
    logic [ADDR_W-1:0] top_addr;
    logic [WORD_W-1:0] top_re, top_im, sample_re;

    assign count_d   = count_q + (ADDR_W+1)'(1);
    assign sample_re = WORD_W'(signed'(Data_in));

    // Sample loads and the engine's top result share the RAM top write port;
    // they never coincide because loads only happen outside RUN.
    assign load_we  = Wr_en && !full_q && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign run_we   = (state_q == S_RUN) && fft_wr_en;
    assign top_we   = load_we || run_we;
    assign top_addr = run_we ? i_top    : count_q[ADDR_W-1:0];
    assign top_re   = run_we ? y_top_re : sample_re;
    assign top_im   = run_we ? y_top_im : '0;

    cplx_ram #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_ram (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .ra_addr_i (i_top),
        .ra_re_o   (x_top_re),
        .ra_im_o   (x_top_im),
        .rb_addr_i (i_bot),
        .rb_re_o   (x_bot_re),
        .rb_im_o   (x_bot_im),
        .hr_addr_i (Rd_addr),
        .hr_re_o   (Rd_re),
        .hr_im_o   (Rd_im),
        .wa_en_i   (top_we),
        .wa_addr_i (top_addr),
        .wa_re_i   (top_re),
        .wa_im_i   (top_im),
        .wb_en_i   (run_we),
        .wb_addr_i (i_bot),
        .wb_re_i   (y_bot_re),
        .wb_im_i   (y_bot_im)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wdog_q  <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_we) begin
                        count_q <= count_d;
                        full_q  <= (count_d == N_CNT);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_we) begin
                        count_q <= count_d;
                        full_q  <= (count_d == N_CNT);
                    end else if (full_q && (Start || (AUTO_START != 0))) begin
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        wdog_q  <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // fft_done takes precedence over a watchdog expiry on the same cycle.
                    if (fft_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if ((TIMEOUT != 0) && (wdog_q == 32'(TIMEOUT - 1))) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                end
                S_DONE: begin
                    if (Ack) begin
                        count_q <= '0;
                        full_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Absolute value in WORD_W+1 bits so the most negative word stays exact.
    function automatic logic [WORD_W:0] abs_ext(input logic [WORD_W-1:0] v);
        logic [WORD_W:0] e;
        e = {v[WORD_W-1], v};
        return v[WORD_W-1] ? -e : e;
    endfunction

    // Built from the registered readout words, so it tracks Rd_re/Rd_im exactly.
    assign Rd_mag    = abs_ext(Rd_re) + abs_ext(Rd_im);
    assign Full      = full_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign fft_start = start_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;

    localparam int DW = 16;
    localparam int WW = 32;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset_n = 1'b1;
    always #5 Clk = ~Clk;

    // ---------------- DUT A signals (manual start, TIMEOUT=8) ----------------
    logic          Wr_en = 1'b0, Start = 1'b0, Ack = 1'b0, fft_done = 1'b0, fft_wr_en = 1'b0;
    logic [DW-1:0] Data_in = '0;
    logic [AW-1:0] Rd_addr = '0, i_top = '0, i_bot = '0;
    logic [WW-1:0] y_top_re = '0, y_top_im = '0, y_bot_re = '0, y_bot_im = '0;
    logic [WW-1:0] Rd_re, Rd_im, x_top_re, x_top_im, x_bot_re, x_bot_im;
    logic [WW:0]   Rd_mag;
    logic          Full, Busy, Done, Err, fft_start;
    logic [1:0]    dbg_state;

    // ---------------- DUT B signals (AUTO_START=1, watchdog off) ----------------
    logic          b_wr_en = 1'b0;
    logic [WW-1:0] b_rd_re, b_rd_im, b_x_top_re, b_x_top_im, b_x_bot_re, b_x_bot_im;
    logic [WW:0]   b_rd_mag;
    logic          b_full, b_busy, b_done, b_err, b_fft_start;
    logic [1:0]    b_state;

    fft_frame_buffer #(.DATA_W(DW), .WORD_W(WW), .ADDR_W(AW), .AUTO_START(0), .TIMEOUT(8)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Wr_en(Wr_en), .Data_in(Data_in), .Start(Start), .Ack(Ack),
        .Rd_addr(Rd_addr), .Rd_re(Rd_re), .Rd_im(Rd_im), .Rd_mag(Rd_mag),
        .Full(Full), .Busy(Busy), .Done(Done), .Err(Err), .fft_start(fft_start), .fft_done(fft_done),
        .i_top(i_top), .i_bot(i_bot), .x_top_re(x_top_re), .x_top_im(x_top_im),
        .x_bot_re(x_bot_re), .x_bot_im(x_bot_im), .fft_wr_en(fft_wr_en),
        .y_top_re(y_top_re), .y_top_im(y_top_im), .y_bot_re(y_bot_re), .y_bot_im(y_bot_im),
        .dbg_state(dbg_state)
    );

    fft_frame_buffer #(.DATA_W(DW), .WORD_W(WW), .ADDR_W(AW), .AUTO_START(1), .TIMEOUT(0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Wr_en(b_wr_en), .Data_in(Data_in), .Start(1'b0), .Ack(1'b0),
        .Rd_addr(Rd_addr), .Rd_re(b_rd_re), .Rd_im(b_rd_im), .Rd_mag(b_rd_mag),
        .Full(b_full), .Busy(b_busy), .Done(b_done), .Err(b_err), .fft_start(b_fft_start),
        .fft_done(1'b0), .i_top('0), .i_bot('0), .x_top_re(b_x_top_re), .x_top_im(b_x_top_im),
        .x_bot_re(b_x_bot_re), .x_bot_im(b_x_bot_im), .fft_wr_en(1'b0),
        .y_top_re('0), .y_top_im('0), .y_bot_re('0), .y_bot_im('0),
        .dbg_state(b_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input int first, input int last, input bit to_b);
        for (int k = first; k <= last; k++) begin
            Data_in = DW'(k - 512);
            if (to_b) b_wr_en = 1'b1;
            else      Wr_en   = 1'b1;
            step();
        end
        Wr_en   = 1'b0;
        b_wr_en = 1'b0;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        #2 Reset_n = 1'b0;
        step();
        step();
        chk("rst_full", Full, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_start", fft_start, 1'b0);
        chk("rst_rd_re", Rd_re, 32'h0);
        chk("rst_rd_mag", Rd_mag, 33'h0);
        chk("rst_state", dbg_state, 2'd0);
        Reset_n = 1'b1;

        // Start before the frame is full is ignored.
        load(0, 9, 1'b0);
        chk("load10_state", dbg_state, 2'd1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("early_start_pulse", fft_start, 1'b0);
        chk("early_start_busy", Busy, 1'b0);
        step();
        chk("early_start_state", dbg_state, 2'd1);

        load(10, 1022, 1'b0);
        chk("full_at_1023", Full, 1'b0);
        load(1023, 1023, 1'b0);
        chk("full_at_1024", Full, 1'b1);

        // 1025th write must not wrap onto address 0.
        Data_in = 16'h7777;
        Wr_en   = 1'b1;
        step();
        Wr_en = 1'b0;
        chk("full_after_extra", Full, 1'b1);
        chk("no_auto_start", fft_start, 1'b0);
        Rd_addr = 10'd3;
        step();
        chk("rd_re_3", Rd_re, 32'hFFFF_FE03);
        chk("rd_im_3", Rd_im, 32'h0);
        chk("rd_mag_3", Rd_mag, 33'd509);
        Rd_addr = 10'd0;
        step();
        chk("rd_re_0_nowrap", Rd_re, 32'hFFFF_FE00);
        Rd_addr = 10'd1023;
        step();
        chk("rd_re_1023", Rd_re, 32'h0000_01FF);

        // Launch the run.
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("run_pulse", fft_start, 1'b1);
        chk("run_busy", Busy, 1'b1);
        chk("run_state", dbg_state, 2'd2);

        // Engine reads are combinational.
        i_top = 10'd2;
        i_bot = 10'd2;
        #1;
        chk("x_top_re_2_pre", x_top_re, 32'hFFFF_FE02);
        chk("x_bot_im_2_pre", x_bot_im, 32'h0);

        // Clashing butterfly write: top wins.
        y_top_re = 32'd5;  y_top_im = 32'hFFFF_FFF9;
        y_bot_re = 32'd9;  y_bot_im = 32'd1;
        fft_wr_en = 1'b1;
        step();
        fft_wr_en = 1'b0;
        chk("single_pulse", fft_start, 1'b0);
        chk("clash_top_re", x_top_re, 32'd5);
        chk("clash_top_im", x_top_im, 32'hFFFF_FFF9);
        chk("clash_bot_re", x_bot_re, 32'd5);

        // Distinct addresses: both writes land.
        i_top = 10'd4;
        i_bot = 10'd5;
        y_top_re = 32'd100;        y_top_im = 32'd200;
        y_bot_re = 32'hFFFF_FF9C;  y_bot_im = 32'd3;
        fft_wr_en = 1'b1;
        step();
        fft_wr_en = 1'b0;
        chk("bf_top_re_4", x_top_re, 32'd100);
        chk("bf_bot_re_5", x_bot_re, 32'hFFFF_FF9C);
        chk("bf_bot_im_5", x_bot_im, 32'd3);

        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        chk("done_flag", Done, 1'b1);
        chk("done_busy", Busy, 1'b0);
        chk("done_err", Err, 1'b0);
        chk("done_state", dbg_state, 2'd3);

        Rd_addr = 10'd2;
        step();
        chk("rd_re_2", Rd_re, 32'd5);
        chk("rd_im_2", Rd_im, 32'hFFFF_FFF9);
        chk("rd_mag_2", Rd_mag, 33'd12);
        Rd_addr = 10'd5;
        step();
        chk("rd_mag_5", Rd_mag, 33'd103);

        // Ack with a simultaneous Wr_en: release only, no first write.
        Ack = 1'b1;
        Wr_en = 1'b1;
        Data_in = 16'h4444;
        step();
        Ack = 1'b0;
        Wr_en = 1'b0;
        chk("ack_state", dbg_state, 2'd0);
        chk("ack_full", Full, 1'b0);
        chk("ack_done", Done, 1'b0);
        Rd_addr = 10'd0;
        step();
        chk("ack_wr_ignored", Rd_re, 32'hFFFF_FE00);
        chk("ack_still_idle", dbg_state, 2'd0);

        // Watchdog: no fft_done for 8 RUN cycles.
        load(0, 1023, 1'b0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("wd_busy0", Busy, 1'b1);
        repeat (7) step();
        chk("wd_busy7", Busy, 1'b1);
        chk("wd_done7", Done, 1'b0);
        step();
        chk("wd_done8", Done, 1'b1);
        chk("wd_err8", Err, 1'b1);
        chk("wd_state8", dbg_state, 2'd3);
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        chk("wd_err_held", Err, 1'b1);
        chk("wd_idle", dbg_state, 2'd0);

        load(0, 1023, 1'b0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("rerun_err_clr", Err, 1'b0);
        chk("rerun_pulse", fft_start, 1'b1);

        // Async reset between edges while fft_start is high.
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 1'b0);
        chk("arst_start", fft_start, 1'b0);
        chk("arst_state", dbg_state, 2'd0);
        chk("arst_full", Full, 1'b0);
        #2 Reset_n = 1'b1;
        Rd_addr = 10'd1000;
        step();
        chk("arst_rd_re", Rd_re, 32'h0000_01E8);
        chk("arst_rd_mag", Rd_mag, 33'd488);
        i_top = 10'd4;
        #1;
        chk("arst_x_top_4", x_top_re, 32'hFFFF_FE04);

        // AUTO_START: fft_start one cycle after the 1024th write.
        load(0, 1023, 1'b1);
        chk("b_full", b_full, 1'b1);
        chk("b_no_pulse_yet", b_fft_start, 1'b0);
        chk("b_state_load", b_state, 2'd1);
        step();
        chk("b_auto_pulse", b_fft_start, 1'b1);
        chk("b_busy", b_busy, 1'b1);
        step();
        chk("b_pulse_end", b_fft_start, 1'b0);
        chk("b_rd_re_1000", b_rd_re, 32'h0000_01E8);
        repeat (20) step();
        chk("b_no_watchdog", b_busy, 1'b1);
        chk("b_err", b_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
